// File: rtl/dvfs_controller_if.sv
// Request channel between the power-management CSR logic and the DVFS sequencer.
interface dvfs_controller_if;
  logic [1:0] lvl_req;
  logic       req_valid;
  logic       req_ready;
  logic       done;
  logic       err;

  modport master (
    output lvl_req,
    output req_valid,
    input  req_ready,
    input  done,
    input  err
  );

  modport slave (
    input  lvl_req,
    input  req_valid,
    output req_ready,
    output done,
    output err
  );
endinterface

// File: rtl/dvfs_controller.sv
// DVFS level-change sequencer: stalls the core, orders voltage/frequency steps so
// voltage always covers the running frequency, and strobes the core clock enable.
module dvfs_controller #(
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter int unsigned VTIMEOUT      = 255
) (
  input  logic               clk_in,
  input  logic               reset,
  dvfs_controller_if.slave   csr,
  input  logic               core_idle,
  output logic               core_stall,
  output logic               clk_en,
  output logic [1:0]         cur_level,
  output logic [1:0]         volt_level,
  output logic               volt_req,
  input  logic               volt_ack
);

  localparam int unsigned SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  typedef enum logic [2:0] {
    IDLE,
    QUIESCE,
    VUP,
    SWITCH,
    SETTLE,
    VDOWN,
    FIN
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [1:0]      tgt;
  logic [1:0]      old_volt;
  logic            speed_up;
  logic            aborted;
  logic [SW-1:0]   settle_cnt;
  logic [7:0]      tmo_cnt;
  logic [2:0]      div_cnt;
  logic            settle_last;
  logic            tmo_hit;

  assign settle_last = (settle_cnt == SW'(SETTLE_CYCLES - 1));
  assign tmo_hit     = (tmo_cnt == 8'(VTIMEOUT));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (csr.req_valid)
                 state_nxt = (csr.lvl_req == cur_level) ? FIN : QUIESCE;
      QUIESCE: if (core_idle)
                 state_nxt = speed_up ? VUP : SWITCH;
      VUP:     if (volt_ack)     state_nxt = SWITCH;
               else if (tmo_hit) state_nxt = FIN;
      SWITCH:  state_nxt = SETTLE;
      SETTLE:  if (settle_last)
                 state_nxt = speed_up ? FIN : VDOWN;
      VDOWN:   if (volt_ack || tmo_hit) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    core_stall = 1'b0;
    volt_req   = 1'b0;
    case (state)
      QUIESCE, SWITCH, SETTLE: core_stall = 1'b1;
      VUP, VDOWN: begin
        core_stall = 1'b1;
        volt_req   = 1'b1;
      end
      default: begin
        core_stall = 1'b0;
        volt_req   = 1'b0;
      end
    endcase
  end

  assign csr.req_ready = (state == IDLE);
  assign csr.done      = (state == FIN) && !aborted;
  assign csr.err       = (state == FIN) && aborted;

  // Strobe when the low cur_level bits of the divider are all zero.
  always_comb begin
    clk_en = 1'b1;
    case (cur_level)
      2'd0:    clk_en = 1'b1;
      2'd1:    clk_en = (div_cnt[0] == 1'b0);
      2'd2:    clk_en = (div_cnt[1:0] == 2'b00);
      default: clk_en = (div_cnt == 3'b000);
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state      <= IDLE;
      cur_level  <= 2'd3;
      volt_level <= 2'd3;
      div_cnt    <= '0;
      tgt        <= 2'd3;
      old_volt   <= 2'd3;
      speed_up   <= 1'b0;
      aborted    <= 1'b0;
      settle_cnt <= '0;
      tmo_cnt    <= '0;
    end else begin
      state   <= state_nxt;
      div_cnt <= (state == SWITCH) ? '0 : div_cnt + 3'd1;

      case (state)
        IDLE: begin
          if (csr.req_valid) begin
            tgt      <= csr.lvl_req;
            speed_up <= (csr.lvl_req < cur_level);
            aborted  <= 1'b0;
            old_volt <= volt_level;
          end
        end
        QUIESCE: begin
          // Raise the voltage code on VUP entry so it is stable for the whole request.
          if (core_idle && speed_up) begin
            volt_level <= tgt;
            tmo_cnt    <= '0;
          end
        end
        VUP, VDOWN: begin
          if (!volt_ack) begin
            if (tmo_hit) begin
              aborted    <= 1'b1;
              volt_level <= old_volt;
            end else begin
              tmo_cnt <= tmo_cnt + 8'd1;
            end
          end
        end
        SWITCH: begin
          cur_level  <= tgt;
          settle_cnt <= '0;
        end
        SETTLE: begin
          settle_cnt <= settle_cnt + 1'b1;
          if (settle_last && !speed_up) begin
            volt_level <= tgt;
            tmo_cnt    <= '0;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dvfs_controller.sv
// Randomized scoreboard bench for dvfs_controller with behavioural core/regulator responders.
module tb_dvfs_controller;

  localparam int unsigned S  = 16;
  localparam int unsigned VT = 255;
  localparam int unsigned NEVER = 1000;

  logic       clk_in = 1'b0;
  logic       reset  = 1'b1;
  logic       core_idle = 1'b0;
  logic       volt_ack  = 1'b0;
  logic       core_stall, clk_en, volt_req;
  logic [1:0] cur_level, volt_level;

  dvfs_controller_if csr();

  dvfs_controller #(.SETTLE_CYCLES(S), .VTIMEOUT(VT)) dut (
    .clk_in     (clk_in),
    .reset      (reset),
    .csr        (csr),
    .core_idle  (core_idle),
    .core_stall (core_stall),
    .clk_en     (clk_en),
    .cur_level  (cur_level),
    .volt_level (volt_level),
    .volt_req   (volt_req),
    .volt_ack   (volt_ack)
  );

  always #5 clk_in = ~clk_in;

  int unsigned cyc = 0;
  always @(posedge clk_in) cyc++;

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;
  bit          hung   = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Core and regulator responders: delays are counted from the rise of core_stall / volt_req.
  int unsigned idle_dly = 0, ack_dly = 0, stall_run = 0, vreq_run = 0;
  always @(negedge clk_in) begin
    if (core_stall) begin
      core_idle = (stall_run >= idle_dly);
      stall_run++;
    end else begin
      core_idle = 1'($urandom);
      stall_run = 0;
    end
    if (volt_req) begin
      volt_ack = (vreq_run >= ack_dly);
      vreq_run++;
    end else begin
      volt_ack = 1'($urandom);
      vreq_run = 0;
    end
  end

  typedef struct {
    bit          is_err;
    bit          slow;
    bit          same;
    bit          lat_known;
    logic [1:0]  tgt;
    logic [1:0]  old_cur;
    logic [1:0]  cur;
    logic [1:0]  volt;
    int unsigned acc;
    int unsigned lat;
    int unsigned vreq;
  } exp_t;

  exp_t       sb[$];
  logic [1:0] m_cur  = 2'd3;
  logic [1:0] m_volt = 2'd3;

  // Scoreboard monitor plus continuous safety checks.
  int unsigned vcyc = 0, scyc = 0;
  logic        pv_req = 1'b0;
  logic [1:0]  pvolt  = 2'd3;
  always @(negedge clk_in) begin
    exp_t e;
    if (reset) begin
      vcyc = 0; scyc = 0; pv_req = 1'b0;
    end else begin
      check("volt_safe", (volt_level <= cur_level), 1);
      if (volt_req) check("volt_req_implies_stall", core_stall, 1);
      if (volt_req && pv_req) check("volt_stable", volt_level, pvolt);
      if (volt_req && !pv_req && sb.size() > 0) begin
        check("volt_rise_level", volt_level, sb[0].tgt);
        check("volt_rise_cur", cur_level, sb[0].slow ? sb[0].tgt : sb[0].old_cur);
      end
      if (volt_req)   vcyc++;
      if (core_stall) scyc++;
      if (csr.done || csr.err) begin
        if (sb.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_completion: done=%0d err=%0d with no request pending (cycle %0d)",
                   csr.done, csr.err, cyc);
        end else begin
          e = sb.pop_front();
          check("done", csr.done, !e.is_err);
          check("err", csr.err, e.is_err);
          check("final_cur_level", cur_level, e.cur);
          check("final_volt_level", volt_level, e.volt);
          check("volt_req_cycles", vcyc, e.vreq);
          if (e.lat_known) begin
            check("latency", cyc - e.acc, e.lat);
            check("stall_cycles", scyc, e.same ? 0 : e.lat - 1);
          end
        end
        vcyc = 0; scyc = 0;
      end
      pv_req = volt_req;
      pvolt  = volt_level;
    end
  end

  // Clock-enable monitor: first strobe right after a ratio change, then every 2**level cycles.
  int unsigned last_en = 0;
  bit          track   = 0;
  logic [1:0]  plvl    = 2'd3;
  always @(negedge clk_in) begin
    if (reset) begin
      track = 0;
    end else begin
      if (!track || cur_level != plvl) begin
        check("clk_en_first", clk_en, 1);
        track   = 1;
        last_en = cyc;
      end else if (clk_en) begin
        check("clk_en_period", cyc - last_en, 32'd1 << cur_level);
        last_en = cyc;
      end else if (cyc - last_en >= (32'd1 << cur_level)) begin
        check("clk_en_missing", clk_en, 1);
        last_en = cyc;
      end
      plvl = cur_level;
    end
  end

  task automatic wait_ready(output bit ok);
    ok = 0;
    for (int i = 0; i < 2000; i++) begin
      if (csr.req_ready) begin
        csr.req_valid = 1'b0;
        ok = 1;
        return;
      end
      // Requests while busy must be dropped, not queued.
      csr.req_valid = 1'($urandom);
      csr.lvl_req   = 2'($urandom);
      @(negedge clk_in);
    end
    csr.req_valid = 1'b0;
    n_chk++;
    $display("FAIL ready_timeout: req_ready low for 2000 cycles, expected 1 (cycle %0d)", cyc);
    hung = 1;
  endtask

  task automatic issue(input logic [1:0] lvl, input int unsigned idly, input int unsigned adly);
    exp_t e;
    bit   ok;
    bit   ack_ok;
    wait_ready(ok);
    if (!ok) return;
    idle_dly    = idly;
    ack_dly     = adly;
    ack_ok      = (adly <= VT);
    e.acc       = cyc;
    e.tgt       = lvl;
    e.old_cur   = m_cur;
    e.same      = (lvl == m_cur);
    e.slow      = (lvl > m_cur);
    e.lat       = 0;
    e.lat_known = 1;
    if (e.same) begin
      e.is_err = 0; e.cur = m_cur; e.volt = m_volt; e.lat = 1; e.vreq = 0;
    end else begin
      e.is_err = !ack_ok;
      e.vreq   = ack_ok ? adly + 1 : VT + 1;
      if (e.slow) begin
        e.cur       = lvl;
        e.volt      = ack_ok ? lvl : m_volt;
        e.lat_known = 0;
      end else begin
        e.cur  = ack_ok ? lvl : m_cur;
        e.volt = ack_ok ? lvl : m_volt;
        e.lat  = ack_ok ? idly + adly + S + 4 : idly + VT + 3;
      end
    end
    m_cur  = e.cur;
    m_volt = e.volt;
    sb.push_back(e);
    csr.lvl_req   = lvl;
    csr.req_valid = 1'b1;
    @(negedge clk_in);
    csr.req_valid = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_cur_level"},  cur_level, 3);
    check({tag, "_volt_level"}, volt_level, 3);
    check({tag, "_req_ready"},  csr.req_ready, 1);
    check({tag, "_core_stall"}, core_stall, 0);
    check({tag, "_volt_req"},   volt_req, 0);
    check({tag, "_done"},       csr.done, 0);
    check({tag, "_err"},        csr.err, 0);
    check({tag, "_clk_en"},     clk_en, 1);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    bit ok;
    csr.req_valid = 1'b0;
    csr.lvl_req   = 2'd0;
    repeat (3) @(posedge clk_in);
    #1 reset = 1'b0;
    @(negedge clk_in);
    check_reset_vals("reset");
    repeat (16) @(negedge clk_in);
    check("idle_cur_level", cur_level, 3);
    check("idle_volt_level", volt_level, 3);

    issue(2'd0, 0, 0);         // speed-up 3->0, immediate idle/ack
    issue(2'd2, 0, 5);         // slow-down 0->2, ack after 5 cycles
    issue(2'd1, 10, 0);        // core_idle held off for 10 cycles
    issue(2'd3, 0, 0);         // slow-down back to 3
    issue(2'd1, 0, NEVER);     // regulator never answers: abort
    issue(2'd2, 0, VT);        // ack on the very last allowed cycle
    issue(2'd2, 0, 0);         // same-level request

    for (int i = 0; i < 30 && !hung; i++) begin
      issue(2'($urandom), $urandom_range(0, 4),
            ($urandom_range(0, 7) == 0) ? NEVER : $urandom_range(0, 6));
    end

    if (!hung) begin
      issue((m_cur == 2'd0) ? 2'd3 : 2'd0, 0, 0);
      repeat (6) @(negedge clk_in);
      @(posedge clk_in);
      #1 reset = 1'b1;
      sb.delete();
      m_cur  = 2'd3;
      m_volt = 2'd3;
      @(posedge clk_in);
      #1 reset = 1'b0;
      @(negedge clk_in);
      check_reset_vals("midreset");
      issue(2'd3, 0, 0);
    end

    wait_ready(ok);
    check("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
